// File: rtl/sdram_ahb_arbiter.sv
// sdram_ahb_arbiter: two-requester round-robin arbiter in front of the
// single AHB-style slave port of sdram_controller. Each transaction is one
// beat. The winner's command is captured, then one HSEL cycle is issued.
// The arbiter waits for HREADY, then pulses ack (with read data) back to
// the winner.
//
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to abort a transaction
// whose HREADY stays low for TIMEOUT_CYC cycles. The abort returns ack
// with out_err = 1 and out_rdata = 0. Without the macro, WAIT lasts
// indefinitely and out_err is tied to 0.
//
// Handshakes:
//   requester side - raise in_req[n] together with in_write[n],
//     in_addrN and in_wdataN, and hold them until out_ack[n] pulses for
//     one cycle. out_rdata and out_err are valid in that ack cycle.
//     Dropping in_req early does not cancel a granted transaction.
//   controller side - out_HSEL is high for exactly one cycle with
//     HWRITE/HADDR/HWDATA valid. Those three stay stable until
//     completion. The first cycle after the HSEL cycle that has
//     in_HREADY = 1 completes the access, with in_HRDATA valid in that
//     cycle.
module sdram_ahb_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              in_HCLK,
  input  logic              in_HRESET,
  input  logic [1:0]        in_req,
  input  logic [1:0]        in_write,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [DATA_W-1:0] in_wdata0,
  input  logic [DATA_W-1:0] in_wdata1,
  output logic [1:0]        out_ack,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  output logic [1:0]        out_grant,
  output logic              out_HSEL,
  output logic              out_HWRITE,
  output logic [ADDR_W-1:0] out_HADDR,
  output logic [DATA_W-1:0] out_HWDATA,
  input  logic              in_HREADY,
  input  logic [DATA_W-1:0] in_HRDATA,
  output logic [1:0]        out_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;     // index of the previous winner
  logic [1:0]          grant_q, grant_d;
  logic                hsel_q, hsel_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                win;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  // Next-state and next-output logic for the arbitration FSM
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    hsel_d  = 1'b0;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 2'b00;
    rdata_d = rdata_q;
    win     = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|in_req) begin
          // With both requesting, the one that did not win last time goes.
          win     = (in_req == 2'b11) ? ~last_q : in_req[1];
          last_d  = win;
          grant_d = win ? 2'b10 : 2'b01;
          wr_d    = in_write[win];
          addr_d  = win ? in_addr1  : in_addr0;
          wdata_d = win ? in_wdata1 : in_wdata0;
          hsel_d  = 1'b1;
          state_d = S_ISSUE;
`ifdef SDRAM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (in_HREADY) begin
          if (!wr_q) rdata_d = in_HRDATA;
          ack_d   = grant_q;
          state_d = S_DONE;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          ack_d   = grant_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight transaction
  always_ff @(posedge in_HCLK or negedge in_HRESET) begin
    if (!in_HRESET) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
      hsel_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      hsel_q  <= hsel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  // WAIT-cycle counter and abort flag
  always_ff @(posedge in_HCLK or negedge in_HRESET) begin
    if (!in_HRESET) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign out_ack       = ack_q;
  assign out_rdata     = rdata_q;
  assign out_grant     = grant_q;
  assign out_HSEL      = hsel_q;
  assign out_HWRITE    = wr_q;
  assign out_HADDR     = addr_q;
  assign out_HWDATA    = wdata_q;
  assign out_dbg_state = state_q;

endmodule

// File: tb/tb_sdram_ahb_arbiter.sv
// Bench for sdram_ahb_arbiter. The bench contains a controller model and a
// round-robin reference model. An ack monitor pops expected responses from
// a scoreboard queue and checks them. Define SDRAM_ARB_TIMEOUT_EN at build
// time to include the abort scenario.
module tb_sdram_ahb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          hready = 1'b0;
  logic [DW-1:0] hrdata = '0;
  logic [1:0]    out_ack, out_grant, dbg_state;
  logic [DW-1:0] out_rdata, out_hwdata;
  logic [AW-1:0] out_haddr;
  logic          out_err, out_hsel, out_hwrite;

  sdram_ahb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .in_HCLK(clk), .in_HRESET(rst_n),
    .in_req({req1, req0}), .in_write({wr1, wr0}),
    .in_addr0(addr0), .in_addr1(addr1),
    .in_wdata0(wdata0), .in_wdata1(wdata1),
    .out_ack(out_ack), .out_rdata(out_rdata), .out_err(out_err),
    .out_grant(out_grant), .out_HSEL(out_hsel), .out_HWRITE(out_hwrite),
    .out_HADDR(out_haddr), .out_HWDATA(out_hwdata),
    .in_HREADY(hready), .in_HRDATA(hrdata),
    .out_dbg_state(dbg_state)
  );

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t exp_q[$];

  // Request lines as the arbiter sees them at each rising edge
  logic [1:0] req_snap = 2'b00;
  always @(posedge clk) req_snap <= {req1, req0};

  // ---------------- controller + reference model ----------------
  int            force_wait = 0;
  bit            use_force_data = 0;
  logic [DW-1:0] force_data = '0;
  bit            busy = 0;
  int            wj = 0, wn = 0;
  logic [DW-1:0] rd_val = '0;
  logic          last_win = 1'b1;
  logic [DW-1:0] last_rd = '0;
  logic          prev_hsel = 1'b0;
  int            win_q[$];
  int            hsel_hist[$];
  int            ack_hist[$];
  logic          m_win, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  exp_t          e_new;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; hready = 1'b0; last_win = 1'b1; last_rd = '0;
      prev_hsel = 1'b0; exp_q.delete();
    end else begin
      hready = 1'b0;
      hrdata = $urandom;
      if (busy) begin
        wj++;
        if (wj == wn) begin
          hready = 1'b1;
          hrdata = rd_val;
          busy   = 0;
        end
      end
      if (out_hsel) begin
        check("hsel_one_cycle", {63'd0, prev_hsel}, 64'd0);
        // Round robin: a lone requester wins; with two, the one not served last.
        m_win   = (req_snap == 2'b11) ? ~last_win : req_snap[1];
        m_wr    = m_win ? wr1 : wr0;
        m_addr  = m_win ? addr1 : addr0;
        m_wdata = m_win ? wdata1 : wdata0;
        check("grant_at_issue", {62'd0, out_grant}, m_win ? 64'd2 : 64'd1);
        check("hwrite", {63'd0, out_hwrite}, {63'd0, m_wr});
        check("haddr", {32'd0, out_haddr}, {32'd0, m_addr});
        if (m_wr) check("hwdata", {32'd0, out_hwdata}, {32'd0, m_wdata});
        last_win = m_win;
        win_q.push_back(int'(m_win));
        hsel_hist.push_back(cyc);
        wn     = (force_wait > 0) ? force_wait : int'($urandom_range(1, 5));
        wj     = 0;
        busy   = 1;
        rd_val = use_force_data ? force_data : DW'($urandom);
        e_new.ack  = m_win ? 2'b10 : 2'b01;
        e_new.err  = 1'b0;
        e_new.due  = cyc + wn + 1;
        e_new.addr = m_addr;
`ifdef SDRAM_ARB_TIMEOUT_EN
        if (wn > TO) begin
          e_new.err = 1'b1;
          e_new.due = cyc + TO + 1;
        end
`endif
        e_new.rdata = e_new.err ? '0 : (m_wr ? last_rd : rd_val);
        last_rd = e_new.rdata;
        exp_q.push_back(e_new);
      end
      prev_hsel = out_hsel;
    end
  end

  // ---------------- ack monitor ----------------
  bit   grant_clear_pending = 0;
  exp_t e_got;

  always @(negedge clk) begin
    if (!rst_n) begin
      grant_clear_pending = 0;
    end else begin
      if (grant_clear_pending) begin
        check("grant_released", {62'd0, out_grant}, 64'd0);
        grant_clear_pending = 0;
      end
      if (out_ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          e_got = exp_q.pop_front();
          check("ack", {62'd0, out_ack}, {62'd0, e_got.ack});
          check("rdata", {32'd0, out_rdata}, {32'd0, e_got.rdata});
          check("err", {63'd0, out_err}, {63'd0, e_got.err});
          check("grant_at_ack", {62'd0, out_grant}, {62'd0, e_got.ack});
          check("haddr_stable", {32'd0, out_haddr}, {32'd0, e_got.addr});
          check("ack_cycle", 64'(cyc), 64'(e_got.due));
          ack_hist.push_back(cyc);
          grant_clear_pending = 1;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        fail_now("ack_late");
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input int r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit drop,
                        output int req_c, output int ack_c);
    bit dropped;
    if (r == 0) begin wr0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin wr1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    req_c = cyc;
    ack_c = -1;
    dropped = 0;
    for (int b = 0; b < 3000; b++) begin
      @(negedge clk);
      if (out_ack[r]) begin
        ack_c = cyc;
        break;
      end
      if (drop && !dropped && out_grant[r]) begin
        if (r == 0) req0 = 1'b0; else req1 = 1'b0;
        dropped = 1;
      end
    end
    if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    if (ack_c < 0) fail_now("ack_timeout");
  endtask

  task automatic rand_stream(input int r, input int n);
    int rc, ac;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(r, 1'($urandom_range(0, 1)), AW'($urandom) & ~AW'(3), DW'($urandom),
             ($urandom_range(0, 7) == 0), rc, ac);
    end
  endtask

  task automatic back_to_back(input int r, input int n);
    int rc, ac;
    for (int i = 0; i < n; i++)
      do_req(r, 1'($urandom_range(0, 1)), AW'($urandom) & ~AW'(3), DW'($urandom), 0, rc, ac);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},    {62'd0, out_ack}, 64'd0);
    check({tag, "_rdata"},  {32'd0, out_rdata}, 64'd0);
    check({tag, "_err"},    {63'd0, out_err}, 64'd0);
    check({tag, "_grant"},  {62'd0, out_grant}, 64'd0);
    check({tag, "_hsel"},   {63'd0, out_hsel}, 64'd0);
    check({tag, "_hwrite"}, {63'd0, out_hwrite}, 64'd0);
    check({tag, "_haddr"},  {32'd0, out_haddr}, 64'd0);
    check({tag, "_hwdata"}, {32'd0, out_hwdata}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "simulation time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int rc0, ac0, rc1, ac1;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single read from requester 0, two WAIT cycles: the ack cycle is the
    // (3 + N)th cycle counting the request cycle as the first.
    force_wait = 2; use_force_data = 1; force_data = 32'hDEADBEEF;
    do_req(0, 1'b0, 32'h10, 32'h0, 0, rc0, ac0);
    check("read_latency", 64'(ac0 - rc0 + 1), 64'd5);
    use_force_data = 0; force_wait = 0;
    @(negedge clk);

    // Single write from requester 1; read data must hold its last value
    do_req(1, 1'b1, 32'h20, 32'hA5A5A5A5, 0, rc1, ac1);
    @(negedge clk);
    check("rdata_held_after_write", {32'd0, out_rdata}, 64'hDEADBEEF);

    // Asynchronous reset in the middle of WAIT
    force_wait = 20;
    wr0 = 1'b0; addr0 = 32'h40; req0 = 1'b1;
    for (int i = 0; i < 50 && !out_hsel; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("no_ack_in_reset", {62'd0, out_ack}, 64'd0);
    #2 rst_n = 1'b1;
    force_wait = 0;
    @(negedge clk);

    // Simultaneous first requests after reset: 0 wins, 1 follows after one idle cycle
    win_q.delete(); hsel_hist.delete(); ack_hist.delete();
    fork
      do_req(0, 1'b0, 32'h100, 32'h0, 0, rc0, ac0);
      do_req(1, 1'b1, 32'h200, 32'h12345678, 0, rc1, ac1);
    join
    check("first_winner_after_reset", 64'(win_q.size() > 0 ? win_q[0] : 9), 64'd0);
    check("rearbitration_gap",
          64'((hsel_hist.size() > 1 && ack_hist.size() > 0) ? hsel_hist[1] - ack_hist[0] : -1),
          64'd2);
    @(negedge clk);

    // Both requesters continuously busy: grants must alternate 0,1,0,1,0,1
    win_q.delete();
    fork
      back_to_back(0, 3);
      back_to_back(1, 3);
    join
    for (int i = 0; i < 6; i++)
      check("alternation", 64'(i < win_q.size() ? win_q[i] : 9), 64'(i % 2));
    @(negedge clk);

    // Randomized traffic from both requesters, including early req drops
    fork
      rand_stream(0, 25);
      rand_stream(1, 25);
    join
    repeat (2) @(negedge clk);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // HREADY never rises: abort with err, then a normal transaction
    force_wait = 1000;
    do_req(0, 1'b0, 32'h300, 32'h0, 0, rc0, ac0);
    force_wait = 0;
    @(negedge clk);
    do_req(1, 1'b0, 32'h304, 32'h0, 0, rc1, ac1);
    repeat (2) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_ahb_arbiter.md
Name: sdram_ahb_arbiter

Overview:
- Two-requester round-robin arbiter in front of sdram_controller's single AHB-style slave port.
- Each requester posts one single-beat read or write and holds it until acknowledged.
- Arbiter captures the winner's command, drives one HSEL cycle to the controller, waits for HREADY, then returns read data and an ack pulse to the winner.
- Sits between the system requesters (e.g. CPU port, DMA port) and sdram_top.

Parameters:
- ADDR_W, 32, address width forwarded to controller.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 64, max cycles in WAIT before abort (only with the optional feature).

Ports:
- in_HCLK  input  1  clock; all logic on rising edge.
- in_HRESET  input  1  asynchronous active-low reset.
- in_req  input  2  per-requester request; held high until the matching ack.
- in_write  input  2  per-requester direction: 1 = write, 0 = read.
- in_addr0 / in_addr1  input  ADDR_W  requester addresses.
- in_wdata0 / in_wdata1  input  DATA_W  requester write data.
- out_ack  output  2  one-cycle completion pulse per requester.
- out_rdata  output  DATA_W  read data, valid in the ack cycle.
- out_err  output  1  high with the ack if the transaction was aborted.
- out_grant  output  2  one-hot, current owner; 0 when idle.
- out_HSEL  output  1  to controller in_HSEL.
- out_HWRITE  output  1  to controller in_HWRITE.
- out_HADDR  output  ADDR_W  to controller in_HADDR.
- out_HWDATA  output  DATA_W  to controller in_HWDATA.
- in_HREADY  input  1  from controller out_HREADY.
- in_HRDATA  input  DATA_W  from controller out_HRDATA.

Behaviour:
- Reset (in_HRESET low, async):
  - state = IDLE, last_grant = 1 (so requester 0 wins first).
  - All outputs 0.
  - Timeout counter 0.
- IDLE:
  - No request: stay in IDLE, out_grant = 0.
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_grant.
  - On grant: latch write/addr/wdata of the winner into holding registers, set out_grant, last_grant <= winner, go to ISSUE.
- ISSUE (1 cycle):
  - out_HSEL = 1; out_HWRITE/out_HADDR/out_HWDATA driven from the holding registers.
  - Next state: WAIT.
- WAIT:
  - out_HSEL = 0; address/data/write remain stable from the holding registers.
  - First cycle with in_HREADY = 1: capture in_HRDATA into out_rdata (reads only; writes leave out_rdata unchanged), go to DONE.
- DONE (1 cycle):
  - out_ack[owner] = 1, out_err = 0.
  - Next cycle: out_grant <= 0, state IDLE.
  - Arbitration resumes in IDLE, so back-to-back grants have at least one idle cycle (minimum period 4 cycles per transaction).
- Latency: req high in IDLE to ack = 3 + N cycles, where N = number of WAIT cycles (N ≥ 1).
- Held request rule:
  - Requester must hold req/addr/wdata until its ack.
  - Dropping req mid-transaction does not abort; the transaction completes and the ack is still issued.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- Registers and output timing:
  - out_HSEL, out_ack and out_err are registered (glitch-free).
  - out_rdata holds its last value between acks.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no ack is issued for the in-flight transaction.

Optional Feature:
- Macro SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If in_HREADY stays low for TIMEOUT_CYC cycles, go to DONE with out_err = 1 and out_rdata = 0.
  - The counter clears on every entry to ISSUE.
- Undefined:
  - No counter; WAIT lasts indefinitely.
  - out_err is tied to 0.

Test Plan:
- Reset then single read: req0=1, write0=0, addr0=0x10, controller HREADY after 2 WAIT cycles with HRDATA=0xDEADBEEF -> one HSEL pulse, ack[0] 5 cycles after req, rdata=0xDEADBEEF, err=0.
- Single write from requester 1: addr1=0x20, wdata1=0xA5A5A5A5 -> HSEL pulse with HWRITE=1, HADDR=0x20, HWDATA=0xA5A5A5A5; ack[1] pulse; out_rdata unchanged.
- Both requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1; never two acks in the same cycle.
- Simultaneous first requests after reset -> requester 0 wins; requester 1 granted immediately after the following IDLE cycle.
- Async reset asserted during WAIT -> all outputs 0 immediately, no ack; after release, next req0 serviced normally with requester 0 first.
- With SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, HREADY held low -> ack with err=1, rdata=0, 8 cycles after entering WAIT; next transaction completes with err=0.
